pong_match_ctrl: RTL and testbench

Match sequencer for the VGA pong game. Owns game state (idle, serve, play, point pause, game over) and both scores, and decides when the paddles and ball may move. It consumes the ball module's boundary-miss flags and a start key, and drives the freeze and ball-recentre controls that the paddle and ball modules currently derive from a raw switch.

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_tick_gen.sv | 19 +
 rtl/pong_match_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_GAMEOVER
  } state_t;

  localparam int SCORE_W       = 4;
  localparam int WIN_SCORE_DEF = 9;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running prescaler; o_tick pulses for one clock when it is all-ones.
module pong_tick_gen #(
  parameter int TICK_BITS = 17
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  logic [TICK_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= r_cnt + TICK_BITS'(1);
  end

  assign o_tick = &r_cnt;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game FSM, scores, serve direction and freeze.
// PONG_SERVE_ALTERNATE_EN: serveDir toggles on every SERVE entry.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = WIN_SCORE_DEF,
  parameter int TICK_BITS   = 17,
  parameter int SERVE_TICKS = 64,
  parameter int POINT_TICKS = 32
) (
  input  logic               CLOCK_50,
  input  logic               SW,
  input  logic               startKeyN,
  input  logic               hitDetectLeft,
  input  logic               hitDetectRight,
  output logic               freeze,
  output logic               ballReset,
  output logic               serveDir,
  output logic [SCORE_W-1:0] scoreLeft,
  output logic [SCORE_W-1:0] scoreRight,
  output logic               gameOver
);

  localparam logic [7:0] L_SERVE = 8'(SERVE_TICKS);
  localparam logic [7:0] L_POINT = 8'(POINT_TICKS);
  localparam logic [SCORE_W-1:0] L_WIN = SCORE_W'(WIN_SCORE);

  state_t r_state;
  state_t w_state_nx;

  logic w_tick;
  logic r_key_s1, r_key_s2, r_key_s3;
  logic w_start;
  logic r_hl_q, r_hr_q;
  logic w_hl_edge, w_hr_edge;
  logic [7:0] r_cnt, w_cnt_nx;
  logic w_cnt_zero, w_win;
  logic w_enter_serve, w_enter_point;
  logic [SCORE_W-1:0] w_sl_nx, w_sr_nx;
  logic w_dir_nx;
  logic w_freeze_nx, w_ball_nx, w_gover_nx;

  pong_tick_gen #(
    .TICK_BITS(TICK_BITS)
  ) u_tick (
    .i_clk (CLOCK_50),
    .i_rst (SW),
    .o_tick(w_tick)
  );

  // Key idles high; third stage gives the falling-edge reference.
  always_ff @(posedge CLOCK_50) begin
    if (SW) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_key_s3 <= 1'b1;
      r_hl_q   <= 1'b0;
      r_hr_q   <= 1'b0;
    end else begin
      r_key_s1 <= startKeyN;
      r_key_s2 <= r_key_s1;
      r_key_s3 <= r_key_s2;
      r_hl_q   <= hitDetectLeft;
      r_hr_q   <= hitDetectRight;
    end
  end

  assign w_start    = r_key_s3 & ~r_key_s2;
  assign w_hl_edge  = hitDetectLeft & ~r_hl_q;
  assign w_hr_edge  = hitDetectRight & ~r_hr_q;
  assign w_cnt_zero = (r_cnt == 8'd0);
  assign w_win      = (scoreLeft == L_WIN) | (scoreRight == L_WIN);

  always_ff @(posedge CLOCK_50) begin
    if (SW) r_state <= ST_IDLE;
    else    r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:
        if (w_start) w_state_nx = ST_SERVE;
      ST_SERVE:
        if (w_tick && w_cnt_zero) w_state_nx = ST_PLAY;
      ST_PLAY:
        unique case (1'b1)
          w_hl_edge && w_hr_edge: w_state_nx = ST_SERVE;
          w_hl_edge ^ w_hr_edge:  w_state_nx = ST_POINT;
          default:                w_state_nx = ST_PLAY;
        endcase
      ST_POINT:
        if (w_tick && w_cnt_zero)
          w_state_nx = w_win ? ST_GAMEOVER : ST_SERVE;
      ST_GAMEOVER:
        if (w_start) w_state_nx = ST_IDLE;
      default:
        w_state_nx = ST_IDLE;
    endcase
  end

  assign w_enter_serve = (w_state_nx == ST_SERVE) && (r_state != ST_SERVE);
  assign w_enter_point = (w_state_nx == ST_POINT) && (r_state != ST_POINT);

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_enter_serve)
      w_cnt_nx = L_SERVE;
    else if (w_enter_point)
      w_cnt_nx = L_POINT;
    else if (w_tick && !w_cnt_zero)
      w_cnt_nx = r_cnt - 8'd1;
  end

  always_comb begin
    w_sl_nx  = scoreLeft;
    w_sr_nx  = scoreRight;
    w_dir_nx = serveDir;
    if (w_enter_point) begin
      if (w_hr_edge) begin
        if (scoreLeft != L_WIN) w_sl_nx = scoreLeft + SCORE_W'(1);
`ifndef PONG_SERVE_ALTERNATE_EN
        w_dir_nx = SERVE_LEFT;
`endif
      end else begin
        if (scoreRight != L_WIN) w_sr_nx = scoreRight + SCORE_W'(1);
`ifndef PONG_SERVE_ALTERNATE_EN
        w_dir_nx = SERVE_RIGHT;
`endif
      end
    end
    if (r_state == ST_GAMEOVER && w_start) begin
      w_sl_nx = '0;
      w_sr_nx = '0;
    end
`ifdef PONG_SERVE_ALTERNATE_EN
    if (w_enter_serve) w_dir_nx = ~serveDir;
`endif
  end

  always_comb begin
    w_freeze_nx = (w_state_nx != ST_PLAY);
    w_ball_nx   = (w_state_nx == ST_IDLE) || (w_state_nx == ST_SERVE);
    w_gover_nx  = (w_state_nx == ST_GAMEOVER);
  end

  always_ff @(posedge CLOCK_50) begin
    if (SW) begin
      r_cnt      <= 8'd0;
      scoreLeft  <= '0;
      scoreRight <= '0;
      serveDir   <= SERVE_LEFT;
      freeze     <= 1'b1;
      ballReset  <= 1'b1;
      gameOver   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nx;
      scoreLeft  <= w_sl_nx;
      scoreRight <= w_sr_nx;
      serveDir   <= w_dir_nx;
      freeze     <= w_freeze_nx;
      ballReset  <= w_ball_nx;
      gameOver   <= w_gover_nx;
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match flow plus random play
// compared against a behavioural match model.
module tb_pong_match_ctrl;

  localparam int TBITS = 2;
  localparam int STK   = 3;
  localparam int PTK   = 2;
  localparam int WS    = 2;
  localparam int PER   = 1 << TBITS;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic sw  = 1'b1;
  logic key = 1'b1;
  logic hl  = 1'b0;
  logic hr  = 1'b0;
  logic freeze, ball_rst, dir, gover;
  logic [3:0] sl, sr;

  int n_chk = 0;
  int n_err = 0;

  int m_st  = M_IDLE;
  int m_sl  = 0;
  int m_sr  = 0;
  int m_dir = 0;
  int m_cyc = 0;
  int m_wait = 0;
  bit m_pl  = 0;
  bit m_pr  = 0;
  bit keyh[$] = '{1, 1, 1, 1};

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE  (WS),
    .TICK_BITS  (TBITS),
    .SERVE_TICKS(STK),
    .POINT_TICKS(PTK)
  ) dut (
    .CLOCK_50      (clk),
    .SW            (sw),
    .startKeyN     (key),
    .hitDetectLeft (hl),
    .hitDetectRight(hr),
    .freeze        (freeze),
    .ballReset     (ball_rst),
    .serveDir      (dir),
    .scoreLeft     (sl),
    .scoreRight    (sr),
    .gameOver      (gover)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Serve waits SERVE_TICKS+1 ticks after entry before releasing.
  task automatic m_enter_serve();
    m_st   = M_SERVE;
    m_wait = STK + 1;
`ifdef PONG_SERVE_ALTERNATE_EN
    m_dir  = 1 - m_dir;
`endif
  endtask

  task automatic model_edge();
    bit tick, press, el, er;
    if (sw) begin
      m_st = M_IDLE; m_sl = 0; m_sr = 0; m_dir = 0;
      m_cyc = 0; m_wait = 0; m_pl = 0; m_pr = 0;
      keyh = '{1, 1, 1, 1};
      return;
    end
    tick = (m_cyc % PER) == PER - 1;
    m_cyc++;
    keyh.push_front(key);
    void'(keyh.pop_back());
    press = keyh[3] && !keyh[2];
    el = hl && !m_pl;
    er = hr && !m_pr;
    m_pl = hl;
    m_pr = hr;
    case (m_st)
      M_IDLE: if (press) m_enter_serve();
      M_SERVE:
        if (tick) begin
          m_wait--;
          if (m_wait == 0) m_st = M_PLAY;
        end
      M_PLAY:
        if (el && er) m_enter_serve();
        else if (er || el) begin
          if (er) begin
            m_sl = (m_sl < WS) ? m_sl + 1 : WS;
`ifndef PONG_SERVE_ALTERNATE_EN
            m_dir = 0;
`endif
          end else begin
            m_sr = (m_sr < WS) ? m_sr + 1 : WS;
`ifndef PONG_SERVE_ALTERNATE_EN
            m_dir = 1;
`endif
          end
          m_st = M_POINT;
          m_wait = PTK + 1;
        end
      M_POINT:
        if (tick) begin
          m_wait--;
          if (m_wait == 0) begin
            if (m_sl == WS || m_sr == WS) m_st = M_OVER;
            else m_enter_serve();
          end
        end
      default:
        if (press) begin
          m_sl = 0; m_sr = 0; m_st = M_IDLE;
        end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("freeze", freeze, m_st != M_PLAY);
    check("ballReset", ball_rst, m_st == M_IDLE || m_st == M_SERVE);
    check("gameOver", gover, m_st == M_OVER);
    check("serveDir", dir, m_dir);
    check("scoreLeft", sl, m_sl);
    check("scoreRight", sr, m_sr);
  endtask

  task automatic wait_play(input int max);
    int n = 0;
    while (freeze !== 1'b0 && n < max) begin step(); n++; end
    if (freeze !== 1'b0) check("wait_play_timeout", freeze, 0);
  endtask

  task automatic press();
    key = 1'b0;
    repeat (2) step();
    key = 1'b1;
  endtask

  initial begin
    int n, first, klow;
    sw = 1'b1;
    repeat (3) step();
    check("rst_freeze", freeze, 1);
    check("rst_ball", ball_rst, 1);
    check("rst_sl", sl, 0);
    sw = 1'b0;
    step();

    key = 1'b0;
    n = 0;
    while (freeze !== 1'b0 && n < 60) begin
      step(); n++;
      if (n == 8) key = 1'b1;
    end
    key = 1'b1;
    check("play_latency_ok", (n >= 16 && n <= 19), 1);

    hr = 1'b1;
    step();
    check("hitR_score", sl, 1);
`ifndef PONG_SERVE_ALTERNATE_EN
    check("hitR_dir", dir, 0);
`endif
    first = 0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (first == 0 && ball_rst === 1'b1) first = i;
    end
    check("hitR_hold", sl, 1);
    check("point_dwell_ok", (first >= 8 && first <= 12), 1);
    hr = 1'b0;

    wait_play(60);
    hl = 1'b1; hr = 1'b1;
    step();
    check("both_sl", sl, 1);
    check("both_sr", sr, 0);
    check("both_serve", ball_rst, 1);
    hl = 1'b0; hr = 1'b0;

    wait_play(60);
    hr = 1'b1;
    step();
    check("win_sl", sl, 2);
    hr = 1'b0;
    n = 0;
    while (gover !== 1'b1 && n < 40) begin step(); n++; end
    check("gameover", gover, 1);
    press();
    repeat (2) step();
    check("idle_sl", sl, 0);
    check("idle_sr", sr, 0);
    check("idle_gover", gover, 0);

    press();
    wait_play(60);
    hl = 1'b1;
    step();
    check("hitL_sr", sr, 1);
    hl = 1'b0;
    wait_play(60);
    sw = 1'b1; hl = 1'b1;
    step();
    check("swrst_sr", sr, 0);
    check("swrst_freeze", freeze, 1);
    check("swrst_ball", ball_rst, 1);
    check("swrst_dir", dir, 0);
    sw = 1'b0; hl = 1'b0;
    step();

    klow = 0;
    for (int c = 0; c < 4000; c++) begin
      sw = ($urandom_range(0, 599) == 0);
      if (klow > 0) begin
        klow--;
        key = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        klow = $urandom_range(1, 8);
        key = 1'b0;
      end else begin
        key = 1'b1;
      end
      if (!hl && !hr && $urandom_range(0, 59) == 0) begin
        hl = 1'b1; hr = 1'b1;
      end else begin
        if ($urandom_range(0, 24) == 0) hl = ~hl;
        if ($urandom_range(0, 24) == 0) hr = ~hr;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
